// File: rtl/amiga_clkgen_ext.sv
// Clock-enable generator on the 28 MHz domain: 7/14 MHz enables, c1/c3/cck phases,
// one-hot E-clock phase with edge strobes, turbo CPU-enable select and E resync handshake.
module amiga_clkgen_ext #(
  parameter int ECLK_W  = 10,
  parameter int ECLK_HI = 4
) (
  input  logic              clk_28,
  input  logic              reset_n,
  input  logic              turbo,
  input  logic              esync_req,
  output logic              clk7_en,
  output logic              clk7n_en,
  output logic              clk14_en,
  output logic              cpu_en,
  output logic              c1,
  output logic              c3,
  output logic              cck,
  output logic [ECLK_W-1:0] eclk,
  output logic              e_high,
  output logic              e_rise,
  output logic              e_fall,
  output logic              esync_ack
);

  // E is high over the top ECLK_HI phases of the one-hot vector
  localparam logic [ECLK_W-1:0] HI_MASK = ~({ECLK_W{1'b1}} >> ECLK_HI);
  localparam logic [ECLK_W-1:0] ECLK_ONE = {{(ECLK_W-1){1'b0}}, 1'b1};

  logic [1:0]        cnt_q, cnt_d;
  logic              clk7_en_q, clk7_en_d;
  logic              clk7n_en_q, clk7n_en_d;
  logic              clk14_en_q, clk14_en_d;
  logic              c1_q, c1_d;
  logic              c3_q, c3_d;
  logic              cck_q, cck_d;
  logic [ECLK_W-1:0] eclk_q, eclk_d;
  logic              pend_q, pend_d;
  logic              ack_q, ack_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              turbo_q, turbo_d;
  logic              rot;
  logic              e_high_cur, e_high_nxt;

  assign rot        = (cnt_q == 2'd1);
  assign e_high_cur = |(eclk_q & HI_MASK);
  assign e_high_nxt = |(eclk_d & HI_MASK);

  always_comb begin
    cnt_d      = cnt_q + 2'd1;
    clk7_en_d  = (cnt_q == 2'd0);
    clk7n_en_d = (cnt_q == 2'd2);
    clk14_en_d = ~cnt_q[0];
    c3_d       = cnt_q[1];
    c1_d       = ~c3_q;
    cck_d      = cck_q;
    eclk_d     = eclk_q;
    ack_d      = 1'b0;
    turbo_d    = turbo_q;
    if (rot) begin
      cck_d = ~cck_q;
      // a pending resync or a corrupted (all-zero) vector restarts at phase 0
      if (pend_q || (eclk_q == '0)) begin
        eclk_d = ECLK_ONE;
      end else begin
        eclk_d = {eclk_q[ECLK_W-2:0], eclk_q[ECLK_W-1]};
      end
      ack_d = pend_q;
    end
    pend_d = esync_req | (pend_q & ~rot);
    rise_d = rot & e_high_nxt & ~e_high_cur;
    fall_d = rot & ~e_high_nxt & e_high_cur;
    if (cnt_q == 2'd3) begin
      turbo_d = turbo;
    end
  end

  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= 2'b10;
      clk7_en_q  <= 1'b1;
      clk7n_en_q <= 1'b1;
      clk14_en_q <= 1'b1;
      c1_q       <= 1'b0;
      c3_q       <= 1'b1;
      cck_q      <= 1'b1;
      eclk_q     <= ECLK_ONE;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      turbo_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clk7_en_q  <= clk7_en_d;
      clk7n_en_q <= clk7n_en_d;
      clk14_en_q <= clk14_en_d;
      c1_q       <= c1_d;
      c3_q       <= c3_d;
      cck_q      <= cck_d;
      eclk_q     <= eclk_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      turbo_q    <= turbo_d;
    end
  end

  assign clk7_en   = clk7_en_q;
  assign clk7n_en  = clk7n_en_q;
  assign clk14_en  = clk14_en_q;
  // turbo_q only changes when neither enable is high, so the switch is glitch-free
  assign cpu_en    = turbo_q ? clk14_en_q : clk7_en_q;
  assign c1        = c1_q;
  assign c3        = c3_q;
  assign cck       = cck_q;
  assign eclk      = eclk_q;
  assign e_high    = e_high_cur;
  assign e_rise    = rise_q;
  assign e_fall    = fall_q;
  assign esync_ack = ack_q;

endmodule
